// File: rtl/exop_ldi_field_pipe_pkg.sv
// exop_ldi_pkg
// Shared definitions for the LDI bitfield-insert unit. It holds the insertion
// mode encoding, the bit positions of the control fields inside idUIxt, and a
// helper that extracts the target lane index.
package exop_ldi_pkg;

  // Insertion modes carried in idUIxt[6:5]. Both 1x codes are reserved and
  // decode as a no-op.
  typedef enum logic [1:0] {
    LDI_MODE_ANCH = 2'b00,
    LDI_MODE_POS  = 2'b01,
    LDI_MODE_RSV2 = 2'b10,
    LDI_MODE_RSV3 = 2'b11
  } ldiMode_e;

  // Bit positions inside idUIxt.
  localparam int IXT_CHAIN   = 7;
  localparam int IXT_MODE_HI = 6;
  localparam int IXT_MODE_LO = 5;
  localparam int IXT_LANE_HI = 3;
  localparam int IXT_LANE_LO = 4;

  // The lane index is assembled from two bits that sit in swapped order:
  // bit 3 is the MSB and bit 4 is the LSB.
  function automatic logic [1:0] lane_of(input logic [7:0] ixt);
    return {ixt[IXT_LANE_HI], ixt[IXT_LANE_LO]};
  endfunction

endpackage

// File: rtl/exop_ldi_field_pipe_if.sv
// exop_ldi_field_pipe_if
// Request and response bundle for the LDI field-insert unit.
//   request : inValid/inReady handshake, idUCmd, idUIxt, valRs, valRi, valPos
//   response: outValid/outReady handshake, valRn, outUCmd, outNop
// The master modport is the operand-fetch/writeback side.
// The slave modport is the unit itself.
interface exop_ldi_field_pipe_if #(
  parameter int DATA_W = 64,
  parameter int LANE_W = 32,
  parameter int IMM_W  = 10
) ();

  logic                      inValid;
  logic                      inReady;
  logic [7:0]                idUCmd;
  logic [7:0]                idUIxt;
  logic [DATA_W-1:0]         valRs;
  logic [IMM_W-1:0]          valRi;
  logic [$clog2(LANE_W)-1:0] valPos;
  logic                      outValid;
  logic                      outReady;
  logic [DATA_W-1:0]         valRn;
  logic [7:0]                outUCmd;
  logic                      outNop;

  modport master (
    output inValid, idUCmd, idUIxt, valRs, valRi, valPos, outReady,
    input  inReady, outValid, valRn, outUCmd, outNop
  );

  modport slave (
    input  inValid, idUCmd, idUIxt, valRs, valRi, valPos, outReady,
    output inReady, outValid, valRn, outUCmd, outNop
  );

endinterface

// File: rtl/exop_ldi_field_pipe_dec.sv
// exop_ldi_field_dec
// Combinational decoder for the prefix-length-encoded immediate.
//   valRi : encoded immediate
//   len   : field length L (the highest set bit index minus one)
//   side  : bit just below the leading one; 0 = low end, 1 = high end
//   value : valRi[L-1:0], with all bits above L forced to zero
//   nop   : immediate carries no field (valRi < 4)
module exop_ldi_field_dec #(
  parameter int IMM_W = 10,
  parameter int LEN_W = $clog2(IMM_W)
) (
  input  logic [IMM_W-1:0] valRi,
  output logic [LEN_W-1:0] len,
  output logic             side,
  output logic [IMM_W-1:0] value,
  output logic             nop
);

  logic [LEN_W-1:0] msb;

  // Priority encoder. The last set bit found in the ascending scan is the
  // leading one. A leading one at bit 0 or 1 leaves no room for a field.
  always_comb begin
    msb = '0;
    for (int i = 0; i < IMM_W; i++) begin
      if (valRi[i]) msb = LEN_W'(i);
    end
    nop = (msb <= LEN_W'(1));
    len = nop ? '0 : msb - LEN_W'(1);

    side = 1'b0;
    for (int i = 1; i < IMM_W; i++) begin
      if (!nop && int'(msb) == i) side = valRi[i-1];
    end

    value = '0;
    for (int i = 0; i < IMM_W; i++) begin
      if (i < int'(len)) value[i] = valRi[i];
    end
  end

endmodule

// File: rtl/exop_ldi_field_pipe.sv
// exop_ldi_field_pipe
// Two-stage bitfield-insert unit for the execute stage.
//   clock : rising-edge clock
//   reset : asynchronous, active-high; drops all in-flight ops
//   bus   : slave side of exop_ldi_field_pipe_if (request/response handshakes)
// S1 decodes the immediate and builds a lane-local mask and value.
// S2 merges them into the base and registers valRn. A chained op uses the
// current valRn as its base, so it sees the result of the op directly ahead
// of it with no bubble.
module exop_ldi_field_pipe
  import exop_ldi_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int LANE_W = 32,
  parameter int IMM_W  = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  exop_ldi_field_pipe_if.slave  bus
);

  localparam int NLANES = DATA_W / LANE_W;
  localparam int LEN_W  = $clog2(IMM_W);
  localparam int SH_W   = $clog2(LANE_W) + 1;

  logic [LEN_W-1:0]  decLen;
  logic              decSide;
  logic [IMM_W-1:0]  decValue;
  logic              decNop;

  ldiMode_e          mode;
  logic [1:0]        laneIdx;
  logic              opNop;
  logic [SH_W-1:0]   shiftAmt;
  logic [LANE_W-1:0] fieldOnes;
  logic [LANE_W-1:0] laneMask;
  logic [LANE_W-1:0] laneVal;

  logic              s1Valid;
  logic [7:0]        s1UCmd;
  logic              s1Chain;
  logic [DATA_W-1:0] s1Rs;
  logic [1:0]        s1Lane;
  logic [LANE_W-1:0] s1Mask;
  logic [LANE_W-1:0] s1Val;
  logic              s1Nop;

  logic              s2Valid;
  logic [DATA_W-1:0] valRnQ;
  logic [7:0]        outUCmdQ;
  logic              outNopQ;

  logic              s2Advance;
  logic              inReadyInt;
  logic [DATA_W-1:0] base;
  logic [DATA_W-1:0] merged;
  logic              unusedIxt;

  exop_ldi_field_dec #(.IMM_W(IMM_W), .LEN_W(LEN_W)) fieldDec (
    .valRi (bus.valRi),
    .len   (decLen),
    .side  (decSide),
    .value (decValue),
    .nop   (decNop)
  );

  assign unusedIxt  = ^bus.idUIxt[2:0];
  assign s2Advance  = !s2Valid || bus.outReady;
  assign inReadyInt = !s1Valid || s2Advance;

  // Build the lane-local mask and value. Both are shifted inside a LANE_W-wide
  // vector, so any field bit shifted past the lane top is dropped. This gives
  // the clipping behaviour in positioned mode. A no-op gets an all-zero mask,
  // so the merge stage passes the base through unchanged.
  always_comb begin
    mode    = ldiMode_e'(bus.idUIxt[IXT_MODE_HI:IXT_MODE_LO]);
    laneIdx = lane_of(bus.idUIxt);
    opNop   = decNop
           || (mode != LDI_MODE_ANCH && mode != LDI_MODE_POS)
           || (int'(laneIdx) >= NLANES);

    if (mode == LDI_MODE_POS)
      shiftAmt = SH_W'(bus.valPos);
    else if (decSide)
      shiftAmt = SH_W'(LANE_W) - SH_W'(decLen);
    else
      shiftAmt = '0;

    fieldOnes = ~({LANE_W{1'b1}} << decLen);
    laneMask  = opNop ? '0 : (fieldOnes << shiftAmt);
    laneVal   = (LANE_W'(decValue) << shiftAmt) & laneMask;
  end

  // S1 register. It loads whenever the stage can hand its op on, or is empty.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1Valid <= 1'b0;
      s1UCmd  <= '0;
      s1Chain <= 1'b0;
      s1Rs    <= '0;
      s1Lane  <= '0;
      s1Mask  <= '0;
      s1Val   <= '0;
      s1Nop   <= 1'b0;
    end else if (inReadyInt) begin
      s1Valid <= bus.inValid;
      if (bus.inValid) begin
        s1UCmd  <= bus.idUCmd;
        s1Chain <= bus.idUIxt[IXT_CHAIN];
        s1Rs    <= bus.valRs;
        s1Lane  <= laneIdx;
        s1Mask  <= laneMask;
        s1Val   <= laneVal;
        s1Nop   <= opNop;
      end
    end
  end

  // Merge. A chained op takes valRnQ as its base, which is the result of the
  // op now leaving S2. Only the selected lane can change.
  always_comb begin
    base   = s1Chain ? valRnQ : s1Rs;
    merged = base;
    for (int k = 0; k < NLANES; k++) begin
      if (int'(s1Lane) == k)
        merged[k*LANE_W +: LANE_W] = (base[k*LANE_W +: LANE_W] & ~s1Mask) | s1Val;
    end
  end

  // S2 register. valRnQ keeps its value after an op is consumed, so a later
  // chained op still finds the most recent result there.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s2Valid  <= 1'b0;
      valRnQ   <= '0;
      outUCmdQ <= '0;
      outNopQ  <= 1'b0;
    end else if (s2Advance) begin
      s2Valid <= s1Valid;
      if (s1Valid) begin
        valRnQ   <= merged;
        outUCmdQ <= s1UCmd;
        outNopQ  <= s1Nop;
      end
    end
  end

  assign bus.inReady  = inReadyInt;
  assign bus.outValid = s2Valid;
  assign bus.valRn    = valRnQ;
  assign bus.outUCmd  = outUCmdQ;
  assign bus.outNop   = outNopQ;

endmodule

// File: tb/tb_exop_ldi_field_pipe.sv
// tb_exop_ldi_field_pipe
// Scoreboard bench for exop_ldi_field_pipe. Accepted requests push their
// expected result into a queue. A monitor pops the queue and compares on
// every output handshake. Expected values come from directed constants or
// from a bit-by-bit reference model of the insert rules.
module tb_exop_ldi_field_pipe;

  localparam int DATA_W = 64;
  localparam int LANE_W = 32;
  localparam int IMM_W  = 10;
  localparam int NLANES = DATA_W / LANE_W;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  ucmd;
    logic        nop;
    int          acceptCycle;
    bit          checkLat;
  } expEntry_t;

  logic        clock;
  logic        reset;
  int          testsRun    = 0;
  int          testsFailed = 0;
  int          cycle       = 0;
  int          readyMode   = 1;
  bit          headSeen    = 0;
  bit          holdPending = 0;
  logic [63:0] heldData;
  logic [7:0]  heldCmd;
  logic        heldNop;
  logic [63:0] lastResult  = 64'd0;
  expEntry_t   sb[$];

  exop_ldi_field_pipe_if #(.DATA_W(DATA_W), .LANE_W(LANE_W), .IMM_W(IMM_W)) bus ();

  exop_ldi_field_pipe #(.DATA_W(DATA_W), .LANE_W(LANE_W), .IMM_W(IMM_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cycle <= cycle + 1;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before 1000000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, actual, expected);
    end
  endtask

  // Reference model. It decodes the leading one and writes the field bit by
  // bit into the chosen lane, dropping any bit that lands past the lane top.
  function automatic logic [63:0] refModel(input logic [63:0] baseIn, input logic [7:0] ixt,
                                           input logic [9:0] ri, input int pos, output bit nop);
    logic [63:0] r;
    int p, lane, mode, len, start;
    r = baseIn;
    p = -1;
    len = 0;
    start = 0;
    for (int i = 0; i < IMM_W; i++) if (ri[i]) p = i;
    lane = 2 * int'(ixt[3]) + int'(ixt[4]);
    mode = int'(ixt[6:5]);
    nop = (p <= 1) || (mode > 1) || (lane >= NLANES);
    if (!nop) begin
      len = p - 1;
      if (mode == 1) start = pos;
      else if (ri[p-1]) start = LANE_W - len;
      else start = 0;
      for (int j = 0; j < len; j++)
        if (start + j < LANE_W) r[lane*LANE_W + start + j] = ri[j];
    end
    return r;
  endfunction

  task automatic pushExpected(input logic [7:0] ixt, input logic [63:0] rs, input logic [9:0] ri,
                              input logic [4:0] pos, input logic [7:0] ucmd,
                              input bit useLit, input logic [63:0] litData, input bit litNop);
    expEntry_t e;
    bit expNop;
    logic [63:0] expData;
    expData = refModel(ixt[7] ? lastResult : rs, ixt, ri, int'(pos), expNop);
    if (useLit) begin
      expData = litData;
      expNop  = litNop;
    end
    lastResult    = expData;
    e.data        = expData;
    e.ucmd        = ucmd;
    e.nop         = expNop;
    e.acceptCycle = cycle;
    e.checkLat    = (readyMode == 1);
    sb.push_back(e);
  endtask

  // Drive one request at the falling edge, then hold it until it is accepted.
  task automatic applyStimulus(input logic [7:0] ixt, input logic [63:0] rs, input logic [9:0] ri,
                               input logic [4:0] pos, input bit useLit,
                               input logic [63:0] litData, input bit litNop);
    logic [7:0] ucmd;
    int tries;
    ucmd = 8'($urandom);
    @(negedge clock);
    bus.inValid = 1'b1;
    bus.idUIxt  = ixt;
    bus.idUCmd  = ucmd;
    bus.valRs   = rs;
    bus.valRi   = ri;
    bus.valPos  = pos;
    #4;
    tries = 0;
    while (bus.inReady !== 1'b1) begin
      tries++;
      if (tries > 100) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL acceptTimeout: got inReady low for %0d cycles, expected acceptance", tries);
        bus.inValid = 1'b0;
        return;
      end
      #10;
    end
    pushExpected(ixt, rs, ri, pos, ucmd, useLit, litData, litNop);
    @(posedge clock);
    #1 bus.inValid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 500) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() > 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL drainTimeout: got %0d results outstanding, expected 0", sb.size());
    end
    repeat (2) @(negedge clock);
  endtask

  // Monitor. It picks outReady for the coming edge, then checks that a stalled
  // output stays stable, and pops and compares on each completed handshake.
  initial begin
    expEntry_t head;
    bus.outReady = 1'b1;
    forever begin
      @(negedge clock);
      case (readyMode)
        0:       bus.outReady = ($urandom_range(0, 3) != 0);
        2:       bus.outReady = 1'b0;
        default: bus.outReady = 1'b1;
      endcase
      if (bus.outValid === 1'b1) begin
        if (holdPending) begin
          checkOutput("holdValRn", bus.valRn, heldData);
          checkOutput("holdUCmd", 64'(bus.outUCmd), 64'(heldCmd));
          checkOutput("holdNop", 64'(bus.outNop), 64'(heldNop));
        end
        if (sb.size() == 0) begin
          testsRun++;
          testsFailed++;
          holdPending = 0;
          $display("[TB] FAIL unexpectedOutput: got valRn 0x%h, expected no output", bus.valRn);
        end else begin
          head = sb[0];
          if (!headSeen && head.checkLat)
            checkOutput("latency", 64'(cycle - head.acceptCycle), 64'd2);
          headSeen = 1;
          if (bus.outReady) begin
            void'(sb.pop_front());
            headSeen    = 0;
            holdPending = 0;
            checkOutput("valRn", bus.valRn, head.data);
            checkOutput("outUCmd", 64'(bus.outUCmd), 64'(head.ucmd));
            checkOutput("outNop", 64'(bus.outNop), 64'(head.nop));
          end else begin
            holdPending = 1;
            heldData    = bus.valRn;
            heldCmd     = bus.outUCmd;
            heldNop     = bus.outNop;
          end
        end
      end else begin
        holdPending = 0;
      end
    end
  end

  initial begin
    logic [63:0] rsA;
    logic [7:0]  ixt;
    logic [9:0]  ri;
    logic [7:0]  ucmd;
    int accepted;

    bus.inValid = 1'b0;
    bus.idUCmd  = '0;
    bus.idUIxt  = '0;
    bus.valRs   = '0;
    bus.valRi   = '0;
    bus.valPos  = '0;
    reset = 1'b1;
    #1;
    checkOutput("resetOutValid", 64'(bus.outValid), 64'd0);
    checkOutput("resetValRn", bus.valRn, 64'd0);
    checkOutput("resetOutUCmd", 64'(bus.outUCmd), 64'd0);
    checkOutput("resetOutNop", 64'(bus.outNop), 64'd0);
    #20;
    @(negedge clock);
    reset = 1'b0;
    #1;
    checkOutput("resetInReady", 64'(bus.inReady), 64'd1);

    $display("[TB] directed cases");
    readyMode = 1;
    rsA = 64'h0123_4567_89AB_CDEF;
    applyStimulus(8'h00, rsA, 10'h2A5, 5'd0, 1, 64'h0123_4567_89AB_CDA5, 1'b0);
    applyStimulus(8'h10, rsA, 10'h03A, 5'd0, 1, 64'hA123_4567_89AB_CDEF, 1'b0);
    applyStimulus(8'h00, rsA, 10'h003, 5'd0, 1, rsA, 1'b1);
    applyStimulus(8'h60, rsA, 10'h2A5, 5'd0, 1, rsA, 1'b1);
    applyStimulus(8'h08, rsA, 10'h2A5, 5'd0, 1, rsA, 1'b1);
    applyStimulus(8'h20, 64'd0, 10'h2A5, 5'd12, 1, 64'h0000_0000_000A_5000, 1'b0);
    applyStimulus(8'h20, 64'd0, 10'h2A5, 5'd28, 1, 64'h0000_0000_5000_0000, 1'b0);
    applyStimulus(8'h00, 64'd0, 10'h2A5, 5'd0, 1, 64'h0000_0000_0000_00A5, 1'b0);
    applyStimulus(8'h80, '1, 10'h03A, 5'd0, 1, 64'h0000_0000_A000_00A5, 1'b0);
    drain();

    $display("[TB] randomized cases");
    readyMode = 0;
    for (int n = 0; n < 300; n++) begin
      ixt = 8'($urandom);
      ixt[6:5] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      ixt[3] = ($urandom_range(0, 7) == 0);
      ri = 10'($urandom);
      applyStimulus(ixt, {$urandom, $urandom}, ri, 5'($urandom), 0, 64'd0, 1'b0);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clock);
    end
    readyMode = 1;
    drain();

    $display("[TB] backpressure");
    readyMode = 2;
    repeat (2) @(negedge clock);
    accepted = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      ucmd = 8'($urandom);
      rsA  = {$urandom, $urandom};
      ri   = 10'($urandom) | 10'h200;
      bus.inValid = 1'b1;
      bus.idUIxt  = 8'h00;
      bus.idUCmd  = ucmd;
      bus.valRs   = rsA;
      bus.valRi   = ri;
      bus.valPos  = '0;
      #4;
      if (bus.inReady === 1'b1) begin
        pushExpected(8'h00, rsA, ri, 5'd0, ucmd, 0, 64'd0, 1'b0);
        accepted++;
      end
    end
    @(posedge clock);
    #1;
    bus.inValid = 1'b0;
    checkOutput("bpAccepted", 64'(accepted), 64'd2);
    checkOutput("bpInReady", 64'(bus.inReady), 64'd0);
    repeat (3) @(negedge clock);
    readyMode = 1;
    drain();

    $display("[TB] reset during stall");
    readyMode = 2;
    repeat (2) @(negedge clock);
    applyStimulus(8'h00, {$urandom, $urandom}, 10'h2A5, 5'd0, 0, 64'd0, 1'b0);
    applyStimulus(8'h10, {$urandom, $urandom}, 10'h03A, 5'd0, 0, 64'd0, 1'b0);
    repeat (2) @(negedge clock);
    checkOutput("stallOutValid", 64'(bus.outValid), 64'd1);
    #2 reset = 1'b1;
    #1;
    checkOutput("asyncResetOutValid", 64'(bus.outValid), 64'd0);
    checkOutput("asyncResetValRn", bus.valRn, 64'd0);
    sb.delete();
    lastResult  = 64'd0;
    headSeen    = 0;
    holdPending = 0;
    readyMode   = 1;
    @(negedge clock);
    #2 reset = 1'b0;
    applyStimulus(8'h80, {$urandom, $urandom}, 10'h2A5, 5'd0, 1, 64'h0000_0000_0000_00A5, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
